// File: rtl/string_char_streamer.sv
// -----------------------------------------------------------------------------
// string_char_streamer
//
// Purpose
//   Fetches one packed string from an external string ROM and streams it out
//   one character per transfer. Character 0 sits in the MSB slice of rom_data.
//   With TRIM_TRAILING=1, trailing SPACE_CODE characters are dropped. A string
//   made only of spaces emits nothing but still produces a done pulse.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle request to stream string str_sel (IDLE only)
//   str_sel     in   requested string index
//   rom_addr    out  string ROM address, latched on an accepted start
//   rom_data    in   packed string from the ROM, read at the end of FETCH
//   char_out    out  current character code
//   char_idx    out  position of char_out within the string
//   char_valid  out  char_out/char_idx are valid (SEND state)
//   char_ready  in   consumer accepts the current character
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse in FINISH
//   err         out  one-cycle pulse, the cycle after a rejected start
//   dbg_state   out  encoded FSM state: 0 IDLE, 1 FETCH, 2 SEND, 3 FINISH
//
// Handshake
//   A character is transferred on every rising edge where char_valid and
//   char_ready are both high. char_valid never depends on char_ready, and
//   while char_ready is low char_out and char_idx are held unchanged.
//
// Timing
//   start sampled in IDLE -> FETCH (one cycle, ROM read latency) -> SEND with
//   char_idx=0, so the first char_valid appears two cycles after start.
//   The transfer at char_idx=L-1 moves to FINISH (done=1 for one cycle), then
//   back to IDLE. Starts seen outside IDLE, including during FINISH, are
//   dropped silently.
// -----------------------------------------------------------------------------
module string_char_streamer #(
  parameter  int CHAR_WIDTH    = 5,
  parameter  int STRING_NUM    = 7,
  parameter  int MAX_CHAR      = 11,
  parameter  int SPACE_CODE    = 28,
  parameter  int TRIM_TRAILING = 1,
  localparam int SEL_W         = $clog2(STRING_NUM + 1),
  localparam int IDX_W         = (MAX_CHAR > 1) ? $clog2(MAX_CHAR) : 1,
  localparam int STR_W         = CHAR_WIDTH * MAX_CHAR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SEL_W-1:0]      str_sel,
  output logic [SEL_W-1:0]      rom_addr,
  input  logic [STR_W-1:0]      rom_data,
  output logic [CHAR_WIDTH-1:0] char_out,
  output logic [IDX_W-1:0]      char_idx,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  // Length needs one more code point than an index: 0..MAX_CHAR.
  localparam int LEN_W = $clog2(MAX_CHAR + 1);

  localparam logic [CHAR_WIDTH-1:0] SPACE_C   = SPACE_CODE[CHAR_WIDTH-1:0];
  localparam logic [SEL_W-1:0]      STR_LIMIT = STRING_NUM[SEL_W-1:0];
  localparam logic [LEN_W-1:0]      FULL_LEN  = MAX_CHAR[LEN_W-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                                 state_q, state_d;
  logic [SEL_W-1:0]                       addr_q, addr_d;
  logic [MAX_CHAR-1:0][CHAR_WIDTH-1:0]    shreg_q, shreg_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [IDX_W-1:0]                       last_q, last_d;
  logic                                   err_q, err_d;

  // ROM word viewed as characters; slice MAX_CHAR-1 holds character 0.
  logic [MAX_CHAR-1:0][CHAR_WIDTH-1:0]    rom_chars;
  logic [LEN_W-1:0]                       trim_len;
  logic [LEN_W-1:0]                       emit_len;

  assign rom_chars = rom_data;

  // Trimmed length = 1 + position of the last non-space character. Scanning
  // from character 0 upward lets the last hit win, which is the rightmost one.
  always_comb begin
    trim_len = '0;
    for (int c = 0; c < MAX_CHAR; c++) begin
      if (rom_chars[MAX_CHAR-1-c] != SPACE_C) begin
        trim_len = LEN_W'(c + 1);
      end
    end
  end

  assign emit_len = (TRIM_TRAILING != 0) ? trim_len : FULL_LEN;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (str_sel < STR_LIMIT) begin
            addr_d  = str_sel;
            state_d = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      FETCH: begin
        // Capture the whole string now so later ROM activity cannot leak in.
        shreg_d = rom_chars;
        idx_d   = '0;
        if (emit_len == '0) begin
          last_d  = '0;
          state_d = FINISH;
        end else begin
          last_d  = IDX_W'(emit_len - LEN_W'(1));
          state_d = SEND;
        end
      end

      SEND: begin
        if (char_ready) begin
          if (idx_q == last_q) begin
            // Final character: hold the index so it never steps past L-1.
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q << CHAR_WIDTH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rom_addr   = addr_q;
  assign char_out   = shreg_q[MAX_CHAR-1];
  assign char_idx   = idx_q;
  assign char_valid = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_string_char_streamer.sv
module tb_string_char_streamer;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        char_ready = 1'b1;
  logic [2:0]  str_sel = 3'd0;

  always #5 clk = ~clk;

  // DUT 0: TRIM_TRAILING=1, DUT 1: TRIM_TRAILING=0; both share stimulus.
  logic [2:0]  rom_addr0, rom_addr1;
  logic [54:0] rom_data0, rom_data1;
  logic [4:0]  char_out0, char_out1;
  logic [3:0]  idx0, idx1;
  logic        valid0, valid1, busy0, busy1, done0, done1, err0, err1;
  logic [1:0]  state0, state1;

  logic [54:0] rom_mem [8];
  int          str_tab [8][11];

  assign rom_data0 = rom_mem[rom_addr0];
  assign rom_data1 = rom_mem[rom_addr1];

  string_char_streamer #(.TRIM_TRAILING(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .str_sel(str_sel),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .char_out(char_out0),
    .char_idx(idx0), .char_valid(valid0), .char_ready(char_ready),
    .busy(busy0), .done(done0), .err(err0), .dbg_state(state0)
  );

  string_char_streamer #(.TRIM_TRAILING(0)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .start(start), .str_sel(str_sel),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .char_out(char_out1),
    .char_idx(idx1), .char_valid(valid1), .char_ready(char_ready),
    .busy(busy1), .done(done1), .err(err1), .dbg_state(state1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: transfers observed at negedge, {idx, char}
  // ---------------------------------------------------------------------------
  logic [8:0] got0_q[$];
  logic [8:0] got1_q[$];
  logic [8:0] exp_q[$];
  int done_cnt0, done_cnt1, err_cnt0, valid_cnt0;
  int n_checks = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (valid0 && char_ready) got0_q.push_back({idx0, char_out0});
    if (valid1 && char_ready) got1_q.push_back({idx1, char_out1});
    if (valid0) valid_cnt0++;
    if (done0)  done_cnt0++;
    if (done1)  done_cnt1++;
    if (err0)   err_cnt0++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic load_rom();
    for (int s = 0; s < 8; s++) begin
      rom_mem[s] = '0;
      for (int i = 0; i < 11; i++) rom_mem[s] = {rom_mem[s][49:0], 5'(str_tab[s][i])};
    end
  endtask

  task automatic clear_sb();
    got0_q.delete(); got1_q.delete();
    done_cnt0 = 0; done_cnt1 = 0; err_cnt0 = 0; valid_cnt0 = 0;
  endtask

  task automatic build_exp(input int sel, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back({4'(i), 5'(str_tab[sel][i])});
  endtask

  task automatic wait_both_idle(input int budget);
    int k = 0;
    while ((busy0 || busy1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (busy0 || busy1) begin
      n_fail++;
      $display("FAIL idle_timeout busy0=%0b busy1=%0b required 0", busy0, busy1);
    end
  endtask

  task automatic run_stream(input int sel);
    clear_sb();
    @(posedge clk); #1;
    start = 1'b1; str_sel = 3'(sel);
    @(posedge clk); #1;
    start = 1'b0;
    wait_both_idle(100);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    n_checks += 8;
    if (valid0 !== 1'b0)     begin n_fail++; $display("FAIL rst_valid got %0b required 0", valid0); end
    if (busy0 !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %0b required 0", busy0); end
    if (done0 !== 1'b0)      begin n_fail++; $display("FAIL rst_done got %0b required 0", done0); end
    if (err0 !== 1'b0)       begin n_fail++; $display("FAIL rst_err got %0b required 0", err0); end
    if (char_out0 !== 5'd0)  begin n_fail++; $display("FAIL rst_char got %0d required 0", char_out0); end
    if (idx0 !== 4'd0)       begin n_fail++; $display("FAIL rst_idx got %0d required 0", idx0); end
    if (rom_addr0 !== 3'd0)  begin n_fail++; $display("FAIL rst_addr got %0d required 0", rom_addr0); end
    if (state0 !== S_IDLE)   begin n_fail++; $display("FAIL rst_state got %0d required 0", state0); end
  endtask

  // "FALL COUNT:" straight out of reset; start is taken on the first edge.
  task automatic test_first_stream();
    clear_sb();
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; str_sel = 3'd1; char_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (state0 !== S_FETCH)  begin n_fail++; $display("FAIL fetch_state got %0d required 1", state0); end
    if (busy0 !== 1'b1)      begin n_fail++; $display("FAIL fetch_busy got %0b required 1", busy0); end
    if (valid0 !== 1'b0)     begin n_fail++; $display("FAIL fetch_valid got %0b required 0", valid0); end
    if (rom_addr0 !== 3'd1)  begin n_fail++; $display("FAIL fetch_addr got %0d required 1", rom_addr0); end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      n_checks += 3;
      if (valid0 !== 1'b1) begin n_fail++; $display("FAIL fall_valid[%0d] got %0b required 1", i, valid0); end
      if (idx0 !== 4'(i))  begin n_fail++; $display("FAIL fall_idx[%0d] got %0d required %0d", i, idx0, i); end
      if (char_out0 !== 5'(str_tab[1][i]))
        begin n_fail++; $display("FAIL fall_char[%0d] got %0d required %0d", i, char_out0, str_tab[1][i]); end
    end
    @(negedge clk);
    n_checks += 2;
    if (done0 !== 1'b1)  begin n_fail++; $display("FAIL fall_done got %0b required 1", done0); end
    if (valid0 !== 1'b0) begin n_fail++; $display("FAIL fall_valid_end got %0b required 0", valid0); end
    @(negedge clk);
    n_checks += 2;
    if (done0 !== 1'b0)  begin n_fail++; $display("FAIL fall_done_pulse got %0b required 0", done0); end
    if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL fall_idle got %0b required 0", busy0); end
    wait_both_idle(40);
  endtask

  // Trailing-space trimming vs. full-length emission.
  task automatic test_trim();
    int sels [4];
    int lens [4];
    sels = '{2, 4, 6, 5};
    lens = '{9, 4, 11, 11};
    for (int t = 0; t < 4; t++) begin
      run_stream(sels[t]);
      build_exp(sels[t], lens[t]);
      n_checks += 2;
      if (got0_q.size() !== exp_q.size())
        begin n_fail++; $display("FAIL trim_count sel=%0d got %0d required %0d", sels[t], got0_q.size(), exp_q.size()); end
      if (done_cnt0 !== 1)
        begin n_fail++; $display("FAIL trim_done sel=%0d got %0d required 1", sels[t], done_cnt0); end
      foreach (exp_q[i]) if (i < got0_q.size()) begin
        n_checks++;
        if (got0_q[i] !== exp_q[i])
          begin n_fail++; $display("FAIL trim_data sel=%0d [%0d] got %h required %h", sels[t], i, got0_q[i], exp_q[i]); end
      end
      build_exp(sels[t], 11);
      n_checks += 2;
      if (got1_q.size() !== 11)
        begin n_fail++; $display("FAIL notrim_count sel=%0d got %0d required 11", sels[t], got1_q.size()); end
      if (done_cnt1 !== 1)
        begin n_fail++; $display("FAIL notrim_done sel=%0d got %0d required 1", sels[t], done_cnt1); end
      foreach (exp_q[i]) if (i < got1_q.size()) begin
        n_checks++;
        if (got1_q[i] !== exp_q[i])
          begin n_fail++; $display("FAIL notrim_data sel=%0d [%0d] got %h required %h", sels[t], i, got1_q[i], exp_q[i]); end
      end
    end
  endtask

  // All-space string: nothing emitted, done straight after FETCH.
  task automatic test_all_space();
    clear_sb();
    @(posedge clk); #1;
    start = 1'b1; str_sel = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (state0 !== S_FETCH) begin n_fail++; $display("FAIL space_fetch got %0d required 1", state0); end
    if (done0 !== 1'b0)     begin n_fail++; $display("FAIL space_done_early got %0b required 0", done0); end
    @(negedge clk);
    n_checks += 2;
    if (done0 !== 1'b1)     begin n_fail++; $display("FAIL space_done_two_after_start got %0b required 1", done0); end
    if (valid0 !== 1'b0)    begin n_fail++; $display("FAIL space_valid got %0b required 0", valid0); end
    @(negedge clk);
    n_checks += 2;
    if (done0 !== 1'b0)     begin n_fail++; $display("FAIL space_done_pulse got %0b required 0", done0); end
    if (busy0 !== 1'b0)     begin n_fail++; $display("FAIL space_idle got %0b required 0", busy0); end
    wait_both_idle(40);
    n_checks += 2;
    if (valid_cnt0 !== 0)   begin n_fail++; $display("FAIL space_valid_cycles got %0d required 0", valid_cnt0); end
    if (done_cnt0 !== 1)    begin n_fail++; $display("FAIL space_done_count got %0d required 1", done_cnt0); end
  endtask

  // Stalls (ready 1,0,0,1...), a start during SEND and a ROM change mid-stream.
  task automatic test_stall();
    logic [4:0] hold_c;
    logic [3:0] hold_i;
    bit stalled;
    clear_sb();
    stalled = 1'b0;
    hold_c = '0;
    hold_i = '0;
    @(posedge clk); #1;
    start = 1'b1; str_sel = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) rom_mem[0][i*5 +: 5] = 5'd31;
    for (int k = 0; k < 60; k++) begin
      char_ready = ((k % 4) == 0) || ((k % 4) == 3);
      start = (k == 2);
      str_sel = 3'd6;
      @(negedge clk);
      if (valid0) begin
        if (stalled) begin
          n_checks += 2;
          if (char_out0 !== hold_c) begin n_fail++; $display("FAIL stall_char got %0d required %0d", char_out0, hold_c); end
          if (idx0 !== hold_i)      begin n_fail++; $display("FAIL stall_idx got %0d required %0d", idx0, hold_i); end
        end
        stalled = !char_ready;
        hold_c = char_out0;
        hold_i = idx0;
      end
      @(posedge clk); #1;
      if (!busy0) break;
    end
    start = 1'b0;
    char_ready = 1'b1;
    wait_both_idle(60);
    load_rom();
    build_exp(0, 11);
    n_checks += 4;
    if (got0_q.size() !== 11) begin n_fail++; $display("FAIL stall_count got %0d required 11", got0_q.size()); end
    if (done_cnt0 !== 1)      begin n_fail++; $display("FAIL stall_done got %0d required 1", done_cnt0); end
    if (err_cnt0 !== 0)       begin n_fail++; $display("FAIL busy_start_err got %0d required 0", err_cnt0); end
    if (rom_addr0 !== 3'd0)   begin n_fail++; $display("FAIL busy_start_addr got %0d required 0", rom_addr0); end
    foreach (exp_q[i]) if (i < got0_q.size()) begin
      n_checks++;
      if (got0_q[i] !== exp_q[i])
        begin n_fail++; $display("FAIL stall_data[%0d] got %h required %h", i, got0_q[i], exp_q[i]); end
    end
  endtask

  // Out-of-range selection.
  task automatic test_err();
    logic [2:0] addr_before;
    addr_before = rom_addr0;
    @(posedge clk); #1;
    start = 1'b1; str_sel = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (err0 !== 1'b1)             begin n_fail++; $display("FAIL err_pulse got %0b required 1", err0); end
    if (busy0 !== 1'b0)            begin n_fail++; $display("FAIL err_busy got %0b required 0", busy0); end
    if (state0 !== S_IDLE)         begin n_fail++; $display("FAIL err_state got %0d required 0", state0); end
    if (rom_addr0 !== addr_before) begin n_fail++; $display("FAIL err_addr got %0d required %0d", rom_addr0, addr_before); end
    @(negedge clk);
    n_checks++;
    if (err0 !== 1'b0)             begin n_fail++; $display("FAIL err_one_cycle got %0b required 0", err0); end
  endtask

  // Start coinciding with done is dropped; the next start in IDLE is taken.
  task automatic test_back_to_back();
    bit found;
    clear_sb();
    found = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; str_sel = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (done0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL b2b_done_timeout got 0 required 1"); end
    start = 1'b1; str_sel = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (busy0 !== 1'b0)     begin n_fail++; $display("FAIL done_start_busy got %0b required 0", busy0); end
    if (err0 !== 1'b0)      begin n_fail++; $display("FAIL done_start_err got %0b required 0", err0); end
    if (rom_addr0 !== 3'd4) begin n_fail++; $display("FAIL done_start_addr got %0d required 4", rom_addr0); end
    wait_both_idle(60);
    run_stream(4);
    n_checks += 2;
    if (got0_q.size() !== 4) begin n_fail++; $display("FAIL b2b_count got %0d required 4", got0_q.size()); end
    if (done_cnt0 !== 1)     begin n_fail++; $display("FAIL b2b_done got %0d required 1", done_cnt0); end
  endtask

  // Reset in the middle of a stream.
  task automatic test_reset_mid();
    bit found;
    clear_sb();
    found = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; str_sel = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (valid0 && idx0 == 4'd4) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rstmid_reach_idx4 got 0 required 1"); end
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (valid0 !== 1'b0)    begin n_fail++; $display("FAIL rstmid_valid got %0b required 0", valid0); end
    if (busy0 !== 1'b0)     begin n_fail++; $display("FAIL rstmid_busy got %0b required 0", busy0); end
    if (idx0 !== 4'd0)      begin n_fail++; $display("FAIL rstmid_idx got %0d required 0", idx0); end
    if (char_out0 !== 5'd0) begin n_fail++; $display("FAIL rstmid_char got %0d required 0", char_out0); end
    if (rom_addr0 !== 3'd0) begin n_fail++; $display("FAIL rstmid_addr got %0d required 0", rom_addr0); end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done_cnt0 !== 0)    begin n_fail++; $display("FAIL rstmid_no_done got %0d required 0", done_cnt0); end
    clear_sb();
    rst_n = 1'b1; start = 1'b1; str_sel = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_both_idle(60);
    build_exp(0, 11);
    n_checks += 2;
    if (got0_q.size() !== 11) begin n_fail++; $display("FAIL rstmid_restart_count got %0d required 11", got0_q.size()); end
    if (done_cnt0 !== 1)      begin n_fail++; $display("FAIL rstmid_restart_done got %0d required 1", done_cnt0); end
    foreach (exp_q[i]) if (i < got0_q.size()) begin
      n_checks++;
      if (got0_q[i] !== exp_q[i])
        begin n_fail++; $display("FAIL rstmid_restart_data[%0d] got %h required %h", i, got0_q[i], exp_q[i]); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    str_tab = '{
      '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10},
      '{5, 0, 11, 11, 28, 2, 14, 20, 13, 19, 26},
      '{1, 2, 3, 4, 5, 6, 7, 8, 9, 28, 28},
      '{28, 28, 28, 28, 28, 28, 28, 28, 28, 28, 28},
      '{28, 3, 28, 4, 28, 28, 28, 28, 28, 28, 28},
      '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 31},
      '{28, 28, 28, 28, 28, 28, 28, 28, 28, 28, 12},
      '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1}
    };
    load_rom();
    clear_sb();
    repeat (2) @(negedge clk);
    test_reset();
    test_first_stream();
    test_trim();
    test_all_space();
    test_stall();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
